// File: rtl/demux_striper_if.sv
// Symbol-stream interface for demux_striper: serial byte input side plus the
// striped multi-lane output side and packet status. The master modport is the
// byte-level receive path; the slave modport is the striper itself.
interface demux_striper_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
);
  logic                 valid_in;
  logic [7:0]           data_in;
  logic [LANES*8-1:0]   data_out;
  logic                 valid_out;
  logic                 in_pkt;
  logic                 framing_err;
  logic [CNT_W-1:0]     pkt_count;

  modport master (
    output valid_in,
    output data_in,
    input  data_out,
    input  valid_out,
    input  in_pkt,
    input  framing_err,
    input  pkt_count
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output data_out,
    output valid_out,
    output in_pkt,
    output framing_err,
    output pkt_count
  );
endinterface

// File: rtl/demux_striper.sv
// demux_striper: filters a serial 8-bit symbol stream (STP/SDP/END -> IDL),
// tracks packet framing, and stripes accepted symbols round-robin into a
// LANES-wide registered word with COM-based lane alignment.
// Optional build macro DEMUX_SKP_DROP_EN: when defined, accepted SKP symbols
// are discarded entirely (no slot, no FSM effect).
module demux_striper #(
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  demux_striper_if.slave   bus
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  typedef enum logic {S_OUT = 1'b0, S_IN = 1'b1} state_t;

  logic [LANES-1:0][7:0] stage_q, stage_d;
  logic [LANES-1:0][7:0] data_q, data_d;
  logic [LANES-1:0][7:0] word;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            mapped;
  logic                  take;
  logic                  is_start;

  // Framing symbols never reach the lanes; they are replaced by idle.
  function automatic logic [7:0] map_sym(input logic [7:0] s);
    if (s == SYM_STP || s == SYM_SDP || s == SYM_END) return SYM_IDL;
    return s;
  endfunction

  // Next-state: packet FSM, slot fill, word completion and COM flush.
  always_comb begin
    stage_d  = stage_q;
    data_d   = data_q;
    ptr_d    = ptr_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    word     = stage_q;
    mapped   = map_sym(bus.data_in);
    is_start = (bus.data_in == SYM_STP) || (bus.data_in == SYM_SDP);
    take     = bus.valid_in;
`ifdef DEMUX_SKP_DROP_EN
    if (bus.data_in == SYM_SKP) take = 1'b0;
`endif
    if (take) begin
      unique case (state_q)
        S_OUT: begin
          if (is_start) state_d = S_IN;
          else if (bus.data_in == SYM_END) err_d = 1'b1;
        end
        S_IN: begin
          if (bus.data_in == SYM_END) begin
            state_d = S_OUT;
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (is_start) begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_OUT;
      endcase

      if (bus.data_in == SYM_COM && ptr_q != '0) begin
        // Unfilled slots already hold IDL, so the partial word is the pad.
        data_d     = stage_q;
        vld_d      = 1'b1;
        stage_d    = {LANES{SYM_IDL}};
        stage_d[0] = SYM_COM;
        ptr_d      = PTR_W'(1);
      end else begin
        for (int k = 0; k < LANES; k++) begin
          if (PTR_W'(k) == ptr_q) word[k] = mapped;
        end
        if (ptr_q == PTR_W'(LANES - 1)) begin
          data_d  = word;
          vld_d   = 1'b1;
          stage_d = {LANES{SYM_IDL}};
          ptr_d   = '0;
        end else begin
          stage_d = word;
          ptr_d   = ptr_q + PTR_W'(1);
        end
      end
    end
  end

  // State registers; reset discards any partial word and idles the lanes.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      stage_q <= {LANES{SYM_IDL}};
      data_q  <= {LANES{SYM_IDL}};
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      state_q <= S_OUT;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.valid_out   = vld_q;
  assign bus.in_pkt      = (state_q == S_IN);
  assign bus.framing_err = err_q;
  assign bus.pkt_count   = cnt_q;

endmodule

// File: tb/tb_demux_striper.sv
module tb_demux_striper;
  localparam int LANES = 4;
  localparam int CNT_W = 8;
  localparam logic [7:0] COM = 8'hBC, SKP = 8'h1C, STP = 8'hFB,
                         SDP = 8'h5C, ENDS = 8'hFD, IDL = 8'h7C;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  demux_striper_if #(.LANES(LANES), .CNT_W(CNT_W)) bus();
  demux_striper #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_L(reset_L), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a queue holds the symbols of the word being built.
  logic [7:0]         m_part[$];
  logic [LANES*8-1:0] m_data;
  logic               m_vld, m_err, m_in;
  logic [CNT_W-1:0]   m_cnt;

  task automatic model_emit();
    for (int k = 0; k < LANES; k++)
      m_data[8*k +: 8] = (k < m_part.size()) ? m_part[k] : IDL;
    m_vld = 1'b1;
    m_part.delete();
  endtask

  task automatic model_sym(input logic v, input logic [7:0] d);
    logic [7:0] mp;
    m_vld = 1'b0;
    m_err = 1'b0;
    if (!v) return;
`ifdef DEMUX_SKP_DROP_EN
    if (d == SKP) return;
`endif
    if (d == STP || d == SDP) begin
      if (m_in) m_err = 1'b1; else m_in = 1'b1;
    end else if (d == ENDS) begin
      if (m_in) begin m_in = 1'b0; m_cnt = m_cnt + 1'b1; end
      else m_err = 1'b1;
    end
    mp = (d == STP || d == SDP || d == ENDS) ? IDL : d;
    if (d == COM && m_part.size() != 0) begin
      model_emit();
      m_part.push_back(COM);
    end else begin
      m_part.push_back(mp);
      if (m_part.size() == LANES) model_emit();
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in  = d;
    model_sym(v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    reset_L = 1'b0;
    m_part.delete();
    m_data = {LANES{IDL}};
    m_vld = 1'b0; m_err = 1'b0; m_in = 1'b0; m_cnt = '0;
    #1;
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.valid_in = 1'b0;
    reset_L = 1'b0;
    #1;
    checks++;
    if (bus.data_out !== 32'h7C7C7C7C || bus.valid_out !== 1'b0 ||
        bus.in_pkt !== 1'b0 || bus.pkt_count !== 8'd0 || bus.framing_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: data=%h vld=%b in=%b cnt=%0d err=%b, want 7c7c7c7c 0 0 0 0",
               bus.data_out, bus.valid_out, bus.in_pkt, bus.pkt_count, bus.framing_err);
    end
    do_reset();
  endtask

  task automatic test_striping();
    logic [7:0] syms [4] = '{STP, 8'h11, 8'h22, 8'h33};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, syms[i]);
      checks++;
      if (bus.valid_out !== (i == 3)) begin
        failures++;
        $display("FAIL stripe_vld[%0d]: got %b want %b", i, bus.valid_out, (i == 3));
      end
    end
    checks++;
    if (bus.data_out !== 32'h3322117C || bus.in_pkt !== 1'b1) begin
      failures++;
      $display("FAIL stripe_word: data=%h in=%b, want 3322117c 1", bus.data_out, bus.in_pkt);
    end
    step(1'b0, 8'h00);
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL stripe_pulse: valid_out=%b want 0", bus.valid_out);
    end
  endtask

  task automatic test_gaps();
    logic       vs [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] ds [7] = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h00, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(vs[i], ds[i]);
      checks++;
      if (bus.valid_out !== (i == 6)) begin
        failures++;
        $display("FAIL gaps_vld[%0d]: got %b want %b", i, bus.valid_out, (i == 6));
      end
    end
    checks++;
    if (bus.data_out !== 32'h44332211) begin
      failures++;
      $display("FAIL gaps_word: got %h want 44332211", bus.data_out);
    end
  endtask

  task automatic test_com_align();
    logic [7:0] ds [6] = '{8'h11, 8'h22, COM, 8'h33, 8'h44, 8'h55};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ds[i]);
      checks++;
      if (bus.valid_out !== (i == 2 || i == 5)) begin
        failures++;
        $display("FAIL com_vld[%0d]: got %b want %b", i, bus.valid_out, (i == 2 || i == 5));
      end
      if (i == 2) begin
        checks++;
        if (bus.data_out !== 32'h7C7C2211) begin
          failures++;
          $display("FAIL com_flush: got %h want 7c7c2211", bus.data_out);
        end
      end
    end
    checks++;
    if (bus.data_out !== 32'h554433BC) begin
      failures++;
      $display("FAIL com_next: got %h want 554433bc", bus.data_out);
    end
  endtask

  task automatic test_framing();
    do_reset();
    step(1'b1, ENDS);
    checks++;
    if (bus.framing_err !== 1'b1 || bus.pkt_count !== 8'd0 || bus.in_pkt !== 1'b0) begin
      failures++;
      $display("FAIL frame_stray_end: err=%b cnt=%0d in=%b want 1 0 0",
               bus.framing_err, bus.pkt_count, bus.in_pkt);
    end
    step(1'b0, 8'h00);
    checks++;
    if (bus.framing_err !== 1'b0) begin
      failures++;
      $display("FAIL frame_pulse: err=%b want 0", bus.framing_err);
    end
    step(1'b1, STP);
    checks++;
    if (bus.framing_err !== 1'b0 || bus.in_pkt !== 1'b1) begin
      failures++;
      $display("FAIL frame_stp: err=%b in=%b want 0 1", bus.framing_err, bus.in_pkt);
    end
    step(1'b1, SDP);
    checks++;
    if (bus.framing_err !== 1'b1 || bus.in_pkt !== 1'b1) begin
      failures++;
      $display("FAIL frame_dup_start: err=%b in=%b want 1 1", bus.framing_err, bus.in_pkt);
    end
    step(1'b1, ENDS);
    checks++;
    if (bus.in_pkt !== 1'b0 || bus.pkt_count !== 8'd1 || bus.framing_err !== 1'b0) begin
      failures++;
      $display("FAIL frame_end: in=%b cnt=%0d err=%b want 0 1 0",
               bus.in_pkt, bus.pkt_count, bus.framing_err);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] ds [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, ds[i]);
    checks++;
    if (bus.data_out !== 32'hDDCCBBAA || bus.valid_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: data=%h vld=%b want ddccbbaa 1", bus.data_out, bus.valid_out);
    end
  endtask

  task automatic test_skp();
    logic [7:0] ds [5] = '{8'h11, SKP, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, ds[i]);
`ifdef DEMUX_SKP_DROP_EN
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL skp_early: valid_out=%b want 0", bus.valid_out);
    end
    step(1'b1, ds[4]);
    checks++;
    if (bus.data_out !== 32'h44332211 || bus.valid_out !== 1'b1) begin
      failures++;
      $display("FAIL skp_drop: data=%h vld=%b want 44332211 1", bus.data_out, bus.valid_out);
    end
`else
    checks++;
    if (bus.data_out !== 32'h33221C11 || bus.valid_out !== 1'b1) begin
      failures++;
      $display("FAIL skp_pass: data=%h vld=%b want 33221c11 1", bus.data_out, bus.valid_out);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] pool [6] = '{COM, SKP, STP, SDP, ENDS, IDL};
    logic       v;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : 8'($urandom);
      step(v, d);
      checks++;
      if (bus.data_out !== m_data || bus.valid_out !== m_vld || bus.in_pkt !== m_in ||
          bus.framing_err !== m_err || bus.pkt_count !== m_cnt) begin
        failures++;
        $display("FAIL random[%0d]: data=%h vld=%b in=%b err=%b cnt=%0d want %h %b %b %b %0d",
                 i, bus.data_out, bus.valid_out, bus.in_pkt, bus.framing_err, bus.pkt_count,
                 m_data, m_vld, m_in, m_err, m_cnt);
      end
    end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    test_reset();
    test_striping();
    test_gaps();
    test_com_align();
    test_framing();
    test_reset_mid_word();
    test_skp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_striper.md
Name: demux_striper

Overview:
- Parametrised successor to the single-byte symbol filter.
- Accepts a serial 8-bit symbol stream and applies the same framing filter: STP, SDP and END become IDL.
- Tracks packet state and stripes accepted symbols round-robin into a LANES-wide registered word, with COM-based lane alignment.
- Sits between the byte-level receive path and the multi-lane datapath.

Parameters:
- LANES, 4, number of 8-bit output lanes; legal values 1, 2, 4, 8.
- CNT_W, 8, width of the completed-packet counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous active-low reset.
- valid_in  input  1  data_in carries a symbol this cycle.
- data_in  input  8  input symbol.
- data_out  output  LANES*8  striped word; lane k at bits [8k+7:8k]; lane 0 holds the first symbol.
- valid_out  output  1  one-cycle pulse: data_out updated with a new word.
- in_pkt  output  1  high between an accepted STP/SDP and the matching END.
- framing_err  output  1  one-cycle pulse on a framing violation.
- pkt_count  output  CNT_W  count of completed packets; wraps modulo 2^CNT_W.

Behaviour:
- Symbol constants: COM=8'hBC, SKP=8'h1C, STP=8'hFB, SDP=8'h5C, END=8'hFD, IDL=8'h7C.
- Reset (async, reset_L=0):
  - Every lane of data_out and of the internal staging word = IDL.
  - valid_out=0, in_pkt=0, framing_err=0, pkt_count=0, lane pointer ptr=0.
  - A partially filled word is discarded.
- valid_in=0:
  - No slot consumed; ptr, staging word and state hold.
  - valid_out=0, framing_err=0.
- Accepted symbol (valid_in=1): mapped and written to staging slot ptr.
  - Mapping: STP/SDP/END → IDL; all other symbols pass unchanged.
  - Then ptr increments.
- Word completion:
  - When the write fills slot LANES-1, the full word (including this symbol) is registered to data_out at that same edge.
  - valid_out=1 for that cycle only; ptr wraps to 0; staging is reset to all IDL.
  - Latency: word visible one clock after its last symbol is presented.
- COM alignment:
  - COM accepted with ptr≠0 flushes the partial word at that edge: slots ptr..LANES-1 padded with IDL, data_out updated, valid_out=1.
  - The COM itself is written to slot 0 of the next word; ptr=1.
  - COM with ptr=0 is handled as a normal symbol.
  - LANES=1: every accepted symbol completes a word, so COM never pads.
- Packet FSM, states OUT (reset) and IN; in_pkt=1 in IN:
  - OUT + STP/SDP → IN.
  - IN + END → OUT; pkt_count+1 at the same edge.
  - OUT + END → stay OUT; framing_err=1; no count.
  - IN + STP/SDP → stay IN; framing_err=1.
  - All other symbols: no state change.
- framing_err and valid_out are registered pulses; both deassert the cycle after, unless retriggered.
- Filtering and FSM both act on every accepted symbol, independent of ptr.

Optional Feature:
- Macro DEMUX_SKP_DROP_EN.
- Defined: accepted SKP symbols are dropped; they consume no slot, ptr holds, no valid_out, and the FSM is unaffected.
- Undefined: SKP is an ordinary pass-through symbol occupying one slot.

Test Plan:
- Reset check, LANES=4: reset_L=0 → data_out=32'h7C7C7C7C, valid_out=0, in_pkt=0, pkt_count=0.
- Striping, LANES=4: STP,11,22,33 on 4 consecutive cycles → after 4th edge data_out=32'h3322117C, valid_out one-cycle pulse, in_pkt=1.
- Gaps: 11, idle, 22, idle idle, 33, 44 → single word 32'h44332211, one valid_out pulse, none during the gaps.
- COM alignment: 11,22,BC,33,44,55 → first data_out=32'h7C7C2211 pulse on BC's edge; then 32'h554433BC.
- Framing and count:
  - END with in_pkt=0 → framing_err pulse, pkt_count stays 0.
  - STP,SDP → framing_err pulse, in_pkt stays 1.
  - END → in_pkt=0, pkt_count=1.
- Reset mid-word and SKP:
  - 11,22, reset_L low one cycle, then AA,BB,CC,DD → 32'hDDCCBBAA.
  - 11,1C,22,33,44 → 32'h3322_1C11 without macro; 32'h44332211 with DEMUX_SKP_DROP_EN.
